// File: rtl/flags_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_flags_pkg
//  Description : Shared types for the NZCV flags unit: the packed flag
//                record, the branch-kind selector and the condition-code
//                encoding used by B.cond.
//  Macros      : none
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_flags_pkg;

    localparam int FLAGS_W = 4;

    // Bit order matches the architectural NZCV nibble {N,Z,C,V}.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {
        COND_OP_NONE  = 2'd0,
        COND_OP_BCOND = 2'd1,
        COND_OP_CBZ   = 2'd2,
        COND_OP_CBNZ  = 2'd3
    } cond_op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_HS = 4'd2,
        COND_LO = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

endpackage
`default_nettype wire

// File: rtl/flags_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : flags_unit_if
//  Description : EX-stage status/branch inputs and flag/branch outputs of the
//                flags unit, bundled as one interface.
//                master : pipeline side (drives EX info, stall, flush)
//                slave  : flags unit (drives flags, br_valid, br_taken,
//                         flags_hazard)
//  Macros      : none
//  Revision    : 1.0  initial release
// ============================================================================
interface flags_unit_if;
    import cpu_flags_pkg::*;

    logic               ex_valid;
    logic               ex_set_flags;
    logic               ex_zero;
    logic               ex_negative;
    logic               ex_carry;
    logic               ex_overflow;
    logic [1:0]         ex_cond_op;
    logic [3:0]         ex_cond;
    logic               ex_reg_zero;
    logic               stall;
    logic               flush;
    logic [FLAGS_W-1:0] flags;
    logic               br_valid;
    logic               br_taken;
    logic               flags_hazard;

    modport master (
        output ex_valid, ex_set_flags, ex_zero, ex_negative, ex_carry,
               ex_overflow, ex_cond_op, ex_cond, ex_reg_zero, stall, flush,
        input  flags, br_valid, br_taken, flags_hazard
    );

    modport slave (
        input  ex_valid, ex_set_flags, ex_zero, ex_negative, ex_carry,
               ex_overflow, ex_cond_op, ex_cond, ex_reg_zero, stall, flush,
        output flags, br_valid, br_taken, flags_hazard
    );

endinterface
`default_nettype wire

// File: rtl/flags_unit_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : cond_eval
//  Description : Combinational B.cond evaluator. Also instantiated by the
//                debug/trace unit, so it carries no pipeline state.
//  Ports       : flags (in)  NZCV record to test
//                cond  (in)  condition code
//                taken (out) 1 when the condition holds
//  Macros      : none
//  Revision    : 1.0  initial release
// ============================================================================
module cond_eval
    import cpu_flags_pkg::*;
(
    input  wire flags_t flags,
    input  wire cond_e  cond,
    output logic        taken
);

    logic gt;
    assign gt = ~flags.z & (flags.n == flags.v);

    always_comb begin
        taken = 1'b1;
        case (cond)
            COND_EQ: taken =  flags.z;
            COND_NE: taken = ~flags.z;
            COND_HS: taken =  flags.c;
            COND_LO: taken = ~flags.c;
            COND_MI: taken =  flags.n;
            COND_PL: taken = ~flags.n;
            COND_VS: taken =  flags.v;
            COND_VC: taken = ~flags.v;
            COND_HI: taken =  (flags.c & ~flags.z);
            COND_LS: taken = ~(flags.c & ~flags.z);
            COND_GE: taken =  (flags.n == flags.v);
            COND_LT: taken =  (flags.n != flags.v);
            COND_GT: taken =  gt;
            COND_LE: taken = ~gt;
            // NV behaves as AL in this architecture.
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
            default: taken = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/flags_unit.sv
`default_nettype none
// ============================================================================
//  Module      : flags_unit
//  Description : Holds architectural NZCV flags with one pending (MEM) stage
//                before commit, and evaluates B.cond / CBZ / CBNZ decisions
//                for the fetch redirect logic.
//  Ports       : clk      (in)  system clock
//                reset_n  (in)  asynchronous active-low reset
//                bus      (slave modport of flags_unit_if)
//                  in : ex_valid, ex_set_flags, ex_zero, ex_negative,
//                       ex_carry, ex_overflow, ex_cond_op[1:0], ex_cond[3:0],
//                       ex_reg_zero, stall, flush
//                  out: flags[3:0] {N,Z,C,V}, br_valid, br_taken (registered),
//                       flags_hazard (combinational)
//  Parameters  : RESET_FLAGS - NZCV loaded into committed/pending on reset
//  Macros      : FLAGS_FWD_EN - forward the pending write into branch
//                evaluation; flags_hazard is then tied low. Undefined: branch
//                sees committed flags only and flags_hazard is raised.
//  Revision    : 1.0  initial release
// ============================================================================
module flags_unit
    import cpu_flags_pkg::*;
#(
    parameter logic [FLAGS_W-1:0] RESET_FLAGS = 4'b0000
) (
    input wire          clk,
    input wire          reset_n,
    flags_unit_if.slave bus
);

    flags_t flags_q;
    flags_t pending_flags_q;
    logic   pending_valid_q;
    logic   br_valid_q;
    logic   br_taken_q;

    flags_t eff_flags;
    flags_t ex_flags;
    logic   accept;
    logic   is_branch;
    logic   bcond_taken;
    logic   decision;
    logic   hazard;
    logic   commit;

    assign accept    = bus.ex_valid & ~bus.stall & ~bus.flush;
    assign is_branch = bus.ex_valid & (bus.ex_cond_op != COND_OP_NONE);
    assign ex_flags  = flags_t'({bus.ex_negative, bus.ex_zero,
                                 bus.ex_carry, bus.ex_overflow});

`ifdef FLAGS_FWD_EN
    assign eff_flags = pending_valid_q ? pending_flags_q : flags_q;
    assign hazard    = 1'b0;
    assign commit    = pending_valid_q & ~bus.stall & ~bus.flush;
`else
    assign eff_flags = flags_q;
    assign hazard    = bus.ex_valid & (bus.ex_cond_op == COND_OP_BCOND)
                     & pending_valid_q;
    // The hazard stall must still let the pending write drain, otherwise the
    // hazard would never clear and the pipeline would deadlock.
    assign commit    = pending_valid_q & ~bus.flush & (~bus.stall | hazard);
`endif

    cond_eval u_cond_eval (
        .flags (eff_flags),
        .cond  (cond_e'(bus.ex_cond)),
        .taken (bcond_taken)
    );

    always_comb begin
        decision = 1'b0;
        case (bus.ex_cond_op)
            COND_OP_BCOND: decision = bcond_taken;
            COND_OP_CBZ:   decision =  bus.ex_reg_zero;
            COND_OP_CBNZ:  decision = ~bus.ex_reg_zero;
            default:       decision = 1'b0;
        endcase
    end

    // Pending (MEM) stage and committed flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q         <= flags_t'(RESET_FLAGS);
            pending_flags_q <= flags_t'(RESET_FLAGS);
            pending_valid_q <= 1'b0;
        end else begin
            if (commit) begin
                flags_q <= pending_flags_q;
            end
            if (bus.flush) begin
                pending_valid_q <= 1'b0;
            end else if (!bus.stall) begin
                pending_valid_q <= accept & bus.ex_set_flags;
                if (accept && bus.ex_set_flags) begin
                    pending_flags_q <= ex_flags;
                end
            end else if (commit) begin
                // Hazard-stall commit: the write is now architectural.
                pending_valid_q <= 1'b0;
            end
        end
    end

    // Registered branch decision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
        end else if (bus.flush) begin
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
        end else if (!bus.stall) begin
            br_valid_q <= is_branch;
            br_taken_q <= is_branch & decision;
        end
    end

    assign bus.flags        = flags_q;
    assign bus.br_valid     = br_valid_q;
    assign bus.br_taken     = br_taken_q;
    assign bus.flags_hazard = hazard;

endmodule
`default_nettype wire

// File: tb/tb_flags_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flags_unit
//  Description : Directed self-checking bench for flags_unit with
//                RESET_FLAGS = 4'b0101. Inputs change on the falling edge,
//                registered outputs are checked on the following falling
//                edge. Works with or without FLAGS_FWD_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_flags_unit;
    import cpu_flags_pkg::*;

    localparam logic [3:0] RST_F = 4'b0101;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    flags_unit_if bus ();

    flags_unit #(.RESET_FLAGS(RST_F)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic ref_cond(input logic [3:0] nzcv, input int c);
        logic n, z, cf, v;
        {n, z, cf, v} = nzcv;
        case (c)
            0:  return z;
            1:  return !z;
            2:  return cf;
            3:  return !cf;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cf && !z;
            9:  return !(cf && !z);
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.ex_valid = 0; bus.ex_set_flags = 0; bus.ex_zero = 0;
        bus.ex_negative = 0; bus.ex_carry = 0; bus.ex_overflow = 0;
        bus.ex_cond_op = COND_OP_NONE; bus.ex_cond = 4'd0;
        bus.ex_reg_zero = 0; bus.stall = 0; bus.flush = 0;
    endtask

    task automatic drive_setflags(input logic [3:0] nzcv);
        drive_idle();
        bus.ex_valid = 1; bus.ex_set_flags = 1;
        {bus.ex_negative, bus.ex_zero, bus.ex_carry, bus.ex_overflow} = nzcv;
    endtask

    task automatic drive_branch(input logic [1:0] op, input logic [3:0] c,
                                input logic rz);
        drive_idle();
        bus.ex_valid = 1; bus.ex_cond_op = op; bus.ex_cond = c;
        bus.ex_reg_zero = rz;
    endtask

    // Write a flag value and let it commit (two edges).
    task automatic load_flags(input logic [3:0] nzcv);
        drive_setflags(nzcv);
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 0;
        tick();
        tick();
        checks++; if (bus.flags !== RST_F) begin failures++;
            $display("FAIL reset_flags: got %b exp %b", bus.flags, RST_F); end
        checks++; if (bus.br_valid !== 1'b0 || bus.br_taken !== 1'b0) begin failures++;
            $display("FAIL reset_br: got %b%b exp 00", bus.br_valid, bus.br_taken); end
        checks++; if (bus.flags_hazard !== 1'b0) begin failures++;
            $display("FAIL reset_hazard: got %b exp 0", bus.flags_hazard); end
        reset_n = 1;
        tick();
        tick();
        tick();
        checks++; if (bus.flags !== RST_F) begin failures++;
            $display("FAIL reset_release_flags: got %b exp %b", bus.flags, RST_F); end
    endtask

    task automatic test_subs_then_bcond();
        drive_setflags(4'b0110);        // N=0 Z=1 C=1 V=0
        tick();
        checks++; if (bus.flags !== RST_F) begin failures++;
            $display("FAIL subs_one_clock: got %b exp %b", bus.flags, RST_F); end
        drive_branch(COND_OP_BCOND, COND_EQ, 1'b0);
        #1;
`ifdef FLAGS_FWD_EN
        checks++; if (bus.flags_hazard !== 1'b0) begin failures++;
            $display("FAIL fwd_hazard: got %b exp 0", bus.flags_hazard); end
        tick();
        checks++; if (bus.flags !== 4'b0110) begin failures++;
            $display("FAIL subs_two_clocks: got %b exp 0110", bus.flags); end
`else
        checks++; if (bus.flags_hazard !== 1'b1) begin failures++;
            $display("FAIL hazard_raised: got %b exp 1", bus.flags_hazard); end
        bus.stall = 1;
        tick();
        checks++; if (bus.flags !== 4'b0110) begin failures++;
            $display("FAIL subs_two_clocks: got %b exp 0110", bus.flags); end
        checks++; if (bus.br_valid !== 1'b0 || bus.flags_hazard !== 1'b0) begin failures++;
            $display("FAIL hazard_stall_state: got br_valid=%b hazard=%b exp 0 0",
                     bus.br_valid, bus.flags_hazard); end
        bus.stall = 0;
        tick();
`endif
        checks++; if (bus.br_valid !== 1'b1 || bus.br_taken !== 1'b1) begin failures++;
            $display("FAIL bcond_eq_after_subs: got %b%b exp 11", bus.br_valid, bus.br_taken); end
        drive_idle();
        tick();
    endtask

    task automatic test_cbz_cbnz();
        logic [3:0] f0;
        f0 = bus.flags;
        drive_branch(COND_OP_CBZ, 4'd0, 1'b1);
        tick();
        checks++; if (bus.br_valid !== 1'b1 || bus.br_taken !== 1'b1) begin failures++;
            $display("FAIL cbz_taken: got %b%b exp 11", bus.br_valid, bus.br_taken); end
        drive_branch(COND_OP_CBNZ, 4'd0, 1'b1);
        tick();
        checks++; if (bus.br_valid !== 1'b1 || bus.br_taken !== 1'b0) begin failures++;
            $display("FAIL cbnz_not_taken: got %b%b exp 10", bus.br_valid, bus.br_taken); end
        drive_branch(COND_OP_CBNZ, 4'd0, 1'b0);
        tick();
        checks++; if (bus.br_valid !== 1'b1 || bus.br_taken !== 1'b1) begin failures++;
            $display("FAIL cbnz_taken: got %b%b exp 11", bus.br_valid, bus.br_taken); end
        drive_idle();
        tick();
        checks++; if (bus.flags !== 4'b0110 || bus.br_valid !== 1'b0) begin failures++;
            $display("FAIL cbz_flags_unchanged: got flags=%b br_valid=%b exp 0110 0",
                     bus.flags, bus.br_valid); end
        if (f0 !== 4'b0110) begin end
    endtask

    task automatic test_cond_sweep();
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            checks++; if (bus.flags !== 4'(f)) begin failures++;
                $display("FAIL sweep_load f=%0d: got %b", f, bus.flags); end
            for (int c = 0; c < 16; c++) begin
                drive_branch(COND_OP_BCOND, 4'(c), 1'b0);
                tick();
                checks++;
                if (bus.br_valid !== 1'b1 || bus.br_taken !== ref_cond(4'(f), c)) begin
                    failures++;
                    $display("FAIL sweep nzcv=%b cond=%0d: got %b%b exp 1%b",
                             4'(f), c, bus.br_valid, bus.br_taken, ref_cond(4'(f), c));
                end
            end
            drive_idle();
        end
        load_flags(4'b1001);
        drive_branch(COND_OP_BCOND, COND_GT, 1'b0);
        tick();
        checks++; if (bus.br_taken !== 1'b1) begin failures++;
            $display("FAIL gt_1001: got %b exp 1", bus.br_taken); end
        load_flags(4'b0100);
        drive_branch(COND_OP_BCOND, COND_LE, 1'b0);
        tick();
        checks++; if (bus.br_taken !== 1'b1) begin failures++;
            $display("FAIL le_0100: got %b exp 1", bus.br_taken); end
        drive_idle();
        tick();
    endtask

    task automatic test_flush();
        load_flags(4'b0000);
        drive_setflags(4'b0100);
        bus.flush = 1;
        tick();
        checks++; if (bus.br_valid !== 1'b0) begin failures++;
            $display("FAIL flush_br_valid: got %b exp 0", bus.br_valid); end
        drive_idle();
        tick();
        tick();
        checks++; if (bus.flags !== 4'b0000) begin failures++;
            $display("FAIL flush_ex_write: got %b exp 0000", bus.flags); end
        drive_setflags(4'b0100);
        tick();
        drive_idle();
        bus.flush = 1;
        tick();
        drive_idle();
        tick();
        checks++; if (bus.flags !== 4'b0000) begin failures++;
            $display("FAIL flush_pending_write: got %b exp 0000", bus.flags); end
        drive_branch(COND_OP_CBZ, 4'd0, 1'b1);
        tick();
        checks++; if (bus.br_valid !== 1'b1) begin failures++;
            $display("FAIL flush_pre_cbz: got %b exp 1", bus.br_valid); end
        drive_branch(COND_OP_CBZ, 4'd0, 1'b1);
        bus.flush = 1;
        bus.stall = 1;                  // flush wins over stall
        tick();
        checks++; if (bus.br_valid !== 1'b0 || bus.br_taken !== 1'b0) begin failures++;
            $display("FAIL flush_over_stall_br: got %b%b exp 00", bus.br_valid, bus.br_taken); end
        drive_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        drive_setflags(4'b0001);
        tick();
        drive_setflags(4'b1000);
        tick();
        checks++; if (bus.flags !== 4'b0001) begin failures++;
            $display("FAIL b2b_first: got %b exp 0001", bus.flags); end
        drive_idle();
        tick();
        checks++; if (bus.flags !== 4'b1000) begin failures++;
            $display("FAIL b2b_second: got %b exp 1000", bus.flags); end
        tick();
    endtask

    task automatic test_stall_reset();
        load_flags(4'b0000);
        drive_setflags(4'b1010);
        tick();
        drive_branch(COND_OP_CBZ, 4'd0, 1'b1);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.flags !== 4'b0000 || bus.br_valid !== 1'b0 || bus.br_taken !== 1'b0) begin
                failures++;
                $display("FAIL stall_freeze cycle %0d: got flags=%b br=%b%b exp 0000 00",
                         i, bus.flags, bus.br_valid, bus.br_taken);
            end
        end
        reset_n = 0;
        #1;
        checks++; if (bus.flags !== RST_F) begin failures++;
            $display("FAIL stall_reset_flags: got %b exp %b", bus.flags, RST_F); end
        @(negedge clk);
        reset_n = 1;
        drive_idle();
        tick();
        tick();
        checks++; if (bus.flags !== RST_F) begin failures++;
            $display("FAIL reset_discards_pending: got %b exp %b", bus.flags, RST_F); end
        // Freeze a taken branch, then reset in the middle of the stall.
        drive_branch(COND_OP_CBZ, 4'd0, 1'b1);
        tick();
        drive_branch(COND_OP_CBNZ, 4'd0, 1'b1);
        bus.stall = 1;
        tick();
        tick();
        checks++; if (bus.br_valid !== 1'b1 || bus.br_taken !== 1'b1) begin failures++;
            $display("FAIL stall_br_hold: got %b%b exp 11", bus.br_valid, bus.br_taken); end
        reset_n = 0;
        #1;
        checks++; if (bus.br_valid !== 1'b0 || bus.br_taken !== 1'b0) begin failures++;
            $display("FAIL stall_reset_br: got %b%b exp 00", bus.br_valid, bus.br_taken); end
        @(negedge clk);
        reset_n = 1;
        drive_idle();
        tick();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_subs_then_bcond();
        test_cbz_cbnz();
        test_cond_sweep();
        test_flush();
        test_back_to_back();
        test_stall_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
